// File: rtl/opc_pkg.sv
// Shared types and helpers for the OPC history block: FSM state encoding,
// default PC width and the circular read-address calculation.
package opc_pkg;

  localparam int OPC_PC_W = 14;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } opc_state_e;

  // Slot holding the entry rd_idx captures back from the newest one; depth is a power of two.
  function automatic int unsigned hist_addr(input int unsigned wr_ptr,
                                            input int unsigned rd_idx,
                                            input int unsigned depth);
    return (wr_ptr - 32'd1 - rd_idx) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/opc_hist_ram.sv
// DEPTH x PC_W history register file: one write port and one registered,
// maskable read port. Storage is deliberately not reset.
module opc_hist_ram #(
  parameter int PC_W  = 14,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [PTR_W-1:0] raddr,
  input  logic             rvalid,
  input  logic             rclr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the array is sampled before any same-edge write lands
  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata <= {PC_W{1'b0}};
    end else if (rvalid) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= {PC_W{1'b0}};
    end
  end

endmodule

// File: rtl/opc_history.sv
// Circular history of captured program-counter values with an indexed read
// port and a PC-match trigger that freezes the history after POST_TRIG captures.
module opc_history
  import opc_pkg::*;
#(
  parameter  int PC_W      = OPC_PC_W,
  parameter  int DEPTH     = 8,
  parameter  int POST_TRIG = 2,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             state_fetch,
  input  logic             opcclk,
  input  logic             opcinh,
  input  logic             clear,
  input  logic             trig_en,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_data,
  output logic [PC_W-1:0]  opc,
  output logic [PTR_W:0]   count,
  output logic             frozen,
  output logic             wrapped
);

  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] POST_CNT = PTR_W'(POST_TRIG);

  opc_state_e       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] post_cnt;
  logic [PTR_W-1:0] rd_addr;
  logic             cap;
  logic             flush;
  logic             rd_valid;
  logic             trig_hit;

  assign flush    = reset | clear;
  assign cap      = (state_fetch | opcclk) & ~opcinh & (state != FROZEN);
  assign trig_hit = trig_en & (pc == trig_pc);
  assign rd_valid = ({1'b0, rd_idx} < count);
  assign rd_addr  = PTR_W'(hist_addr(32'(wr_ptr), 32'(rd_idx), 32'(DEPTH)));
  assign frozen   = (state == FROZEN);

  // Pointer, occupancy, OPC register and trigger FSM
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= {PTR_W{1'b0}};
      count    <= {(PTR_W+1){1'b0}};
      wrapped  <= 1'b0;
      post_cnt <= {PTR_W{1'b0}};
      opc      <= {PC_W{1'b0}};
      state    <= RUN;
    end else if (cap) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      opc    <= pc;
      if (count == FULL) begin
        wrapped <= 1'b1;
      end else begin
        count <= count + (PTR_W+1)'(1);
      end
      case (state)
        RUN: begin
          if (trig_hit) begin
            if (POST_TRIG == 0) begin
              state <= FROZEN;
            end else begin
              state    <= POST;
              post_cnt <= POST_CNT;
            end
          end else begin
            state <= RUN;
          end
        end
        POST: begin
          if (post_cnt == PTR_W'(1)) begin
            state    <= FROZEN;
            post_cnt <= {PTR_W{1'b0}};
          end else begin
            post_cnt <= post_cnt - PTR_W'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end else begin
      state <= state;
    end
  end

  opc_hist_ram #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we     (cap & ~flush),
    .waddr  (wr_ptr),
    .wdata  (pc),
    .raddr  (rd_addr),
    .rvalid (rd_valid),
    .rclr   (flush),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_opc_history.sv
// Directed self-checking bench for opc_history with default parameters
// (PC_W=14, DEPTH=8, POST_TRIG=2).
module tb_opc_history;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] pc;
  logic        state_fetch;
  logic        opcclk;
  logic        opcinh;
  logic        clear;
  logic        trig_en;
  logic [13:0] trig_pc;
  logic [2:0]  rd_idx;
  logic [13:0] rd_data;
  logic [13:0] opc;
  logic [3:0]  count;
  logic        frozen;
  logic        wrapped;

  int checks = 0;
  int errors = 0;

  opc_history dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .state_fetch (state_fetch),
    .opcclk      (opcclk),
    .opcinh      (opcinh),
    .clear       (clear),
    .trig_en     (trig_en),
    .trig_pc     (trig_pc),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .opc         (opc),
    .count       (count),
    .frozen      (frozen),
    .wrapped     (wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cap(input logic [13:0] p);
    pc          = p;
    state_fetch = 1'b1;
    tick();
    state_fetch = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (opc !== 14'h0 || count !== 4'd0 || frozen !== 1'b0 || wrapped !== 1'b0 || rd_data !== 14'h0) begin
      errors++;
      $display("FAIL reset: opc=%h count=%0d frozen=%b wrapped=%b rd_data=%h, want all 0",
               opc, count, frozen, wrapped, rd_data);
    end
  endtask

  task automatic test_capture;
    logic [13:0] exp_rd [4];
    exp_rd[0] = 14'h0102; exp_rd[1] = 14'h0101; exp_rd[2] = 14'h0100; exp_rd[3] = 14'h0000;
    do_cap(14'h0100);
    do_cap(14'h0101);
    do_cap(14'h0102);
    checks++;
    if (opc !== 14'h0102 || count !== 4'd3) begin
      errors++;
      $display("FAIL capture_opc_count: opc=%h count=%0d, want 0102 3", opc, count);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 3'(i);
      tick();
      checks++;
      if (rd_data !== exp_rd[i]) begin
        errors++;
        $display("FAIL capture_read idx%0d: got %h want %h", i, rd_data, exp_rd[i]);
      end
    end
  endtask

  task automatic test_read_during_cap;
    rd_idx = 3'd0;
    do_cap(14'h0103);
    checks++;
    if (rd_data !== 14'h0102) begin
      errors++;
      $display("FAIL read_during_cap: got %h want 0102", rd_data);
    end
    checks++;
    if (opc !== 14'h0103 || count !== 4'd4) begin
      errors++;
      $display("FAIL read_during_cap_state: opc=%h count=%0d, want 0103 4", opc, count);
    end
  endtask

  task automatic test_inhibit;
    opcinh = 1'b1;
    do_cap(14'h3FFF);
    opcinh = 1'b0;
    checks++;
    if (opc !== 14'h0103 || count !== 4'd4) begin
      errors++;
      $display("FAIL inhibit: opc=%h count=%0d, want 0103 4", opc, count);
    end
    pc     = 14'h0005;
    opcclk = 1'b1;
    tick();
    opcclk = 1'b0;
    checks++;
    if (opc !== 14'h0005 || count !== 4'd5) begin
      errors++;
      $display("FAIL opcclk_cap: opc=%h count=%0d, want 0005 5", opc, count);
    end
  endtask

  task automatic test_wrap;
    logic [13:0] exp_rd [3];
    logic [2:0]  idx    [3];
    exp_rd[0] = 14'd10; exp_rd[1] = 14'd6; exp_rd[2] = 14'd3;
    idx[0]    = 3'd0;   idx[1]    = 3'd4;  idx[2]    = 3'd7;
    do_clear();
    checks++;
    if (count !== 4'd0 || opc !== 14'h0) begin
      errors++;
      $display("FAIL wrap_clear: count=%0d opc=%h, want 0 0", count, opc);
    end
    for (int i = 1; i <= 8; i++) do_cap(14'(i));
    checks++;
    if (count !== 4'd8 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full: count=%0d wrapped=%b, want 8 0", count, wrapped);
    end
    do_cap(14'd9);
    do_cap(14'd10);
    checks++;
    if (count !== 4'd8 || wrapped !== 1'b1 || opc !== 14'd10) begin
      errors++;
      $display("FAIL wrap_over: count=%0d wrapped=%b opc=%0d, want 8 1 10", count, wrapped, opc);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = idx[i];
      tick();
      checks++;
      if (rd_data !== exp_rd[i]) begin
        errors++;
        $display("FAIL wrap_read idx%0d: got %0d want %0d", idx[i], rd_data, exp_rd[i]);
      end
    end
  endtask

  task automatic test_trigger;
    logic exp_frz;
    do_clear();
    trig_en = 1'b1;
    trig_pc = 14'h0040;
    for (int p = 14'h3E; p <= 14'h45; p++) begin
      do_cap(14'(p));
      exp_frz = (p >= 14'h42);
      checks++;
      if (frozen !== exp_frz) begin
        errors++;
        $display("FAIL trig_frozen after %h: got %b want %b", p, frozen, exp_frz);
      end
    end
    trig_en = 1'b0;
    checks++;
    if (opc !== 14'h0042 || count !== 4'd5) begin
      errors++;
      $display("FAIL trig_hold: opc=%h count=%0d, want 0042 5", opc, count);
    end
    rd_idx = 3'd2;
    tick();
    checks++;
    if (rd_data !== 14'h0040) begin
      errors++;
      $display("FAIL trig_read idx2: got %h want 0040", rd_data);
    end
  endtask

  task automatic test_clear_frozen;
    rd_idx      = 3'd0;
    pc          = 14'h1234;
    state_fetch = 1'b1;
    clear       = 1'b1;
    tick();
    state_fetch = 1'b0;
    clear       = 1'b0;
    checks++;
    if (count !== 4'd0 || frozen !== 1'b0 || opc !== 14'h0 || rd_data !== 14'h0) begin
      errors++;
      $display("FAIL clear_frozen: count=%0d frozen=%b opc=%h rd_data=%h, want 0 0 0 0",
               count, frozen, opc, rd_data);
    end
    do_cap(14'h0777);
    checks++;
    if (opc !== 14'h0777 || count !== 4'd1) begin
      errors++;
      $display("FAIL clear_recap: opc=%h count=%0d, want 0777 1", opc, count);
    end
    tick();
    checks++;
    if (rd_data !== 14'h0777) begin
      errors++;
      $display("FAIL clear_read: got %h want 0777", rd_data);
    end
  endtask

  task automatic test_reset_post;
    do_clear();
    trig_en = 1'b1;
    trig_pc = 14'h0040;
    do_cap(14'h0040);
    do_cap(14'h0041);
    checks++;
    if (frozen !== 1'b0) begin
      errors++;
      $display("FAIL post_pending: frozen=%b want 0", frozen);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (opc !== 14'h0 || count !== 4'd0 || frozen !== 1'b0 || wrapped !== 1'b0 || rd_data !== 14'h0) begin
      errors++;
      $display("FAIL reset_post: opc=%h count=%0d frozen=%b wrapped=%b rd_data=%h, want all 0",
               opc, count, frozen, wrapped, rd_data);
    end
    do_cap(14'h0050);
    checks++;
    if (frozen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: frozen=%b want 0", frozen);
    end
    do_cap(14'h0040);
    do_cap(14'h0041);
    checks++;
    if (frozen !== 1'b0) begin
      errors++;
      $display("FAIL retrig_post: frozen=%b want 0", frozen);
    end
    do_cap(14'h0042);
    checks++;
    if (frozen !== 1'b1 || opc !== 14'h0042) begin
      errors++;
      $display("FAIL retrig_frozen: frozen=%b opc=%h, want 1 0042", frozen, opc);
    end
    trig_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    pc          = 14'h0;
    state_fetch = 1'b0;
    opcclk      = 1'b0;
    opcinh      = 1'b0;
    clear       = 1'b0;
    trig_en     = 1'b0;
    trig_pc     = 14'h0;
    rd_idx      = 3'd0;
    test_reset();
    test_capture();
    test_read_during_cap();
    test_inhibit();
    test_wrap();
    test_trigger();
    test_clear_frozen();
    test_reset_post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opc_history.md
Name: opc_history

Overview:
- Parametrised successor to the single old-PC save register.
- Keeps a circular history of the last DEPTH program-counter values latched at fetch/opcclk, instead of only one.
- Exposes the most recent entry as opc for existing datapath consumers.
- Adds an indexed, registered debug/spy read port and a PC-match trigger that freezes the history a programmable number of captures after the match.

Parameters:
- PC_W, 14, PC/OPC width in bits.
- DEPTH, 8, history entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer/index width (derived, not overridden).
- POST_TRIG, 2, captures taken after the trigger capture before freezing; range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  PC_W  current PC.
- state_fetch  in  1  fetch-state strobe.
- opcclk  in  1  explicit OPC clock enable.
- opcinh  in  1  inhibit; blocks capture.
- clear  in  1  synchronous history clear/re-arm.
- trig_en  in  1  arm PC-match trigger.
- trig_pc  in  PC_W  trigger match value.
- rd_idx  in  PTR_W  history index; 0 = most recent.
- rd_data  out  PC_W  registered history read.
- opc  out  PC_W  most recently captured PC.
- count  out  PTR_W+1  valid entries, saturating at DEPTH.
- frozen  out  1  history frozen by trigger.
- wrapped  out  1  sticky; set once an entry has been overwritten.

Behaviour:
- Capture strobe: cap = (state_fetch | opcclk) & ~opcinh & (state != FROZEN).
- On cap:
  - mem[wr_ptr] <= pc.
  - wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
  - opc <= pc.
  - count <= min(count+1, DEPTH).
  - If count == DEPTH before the capture, wrapped <= 1.
- Read path:
  - rd_data is registered, 1-cycle latency.
  - Each cycle, rd_data <= mem[(wr_ptr-1-rd_idx) mod DEPTH] if rd_idx < count, else 0.
  - The read uses pre-capture state. A capture and a read in the same cycle return the older view.
- State machine (reset/clear state RUN):
  - RUN: on cap with trig_en=1 and pc==trig_pc, the matching pc is stored. Then go to FROZEN if POST_TRIG==0. Otherwise go to POST with post_cnt <= POST_TRIG.
  - RUN: a match while trig_en=0 is ignored.
  - POST: each cap decrements post_cnt. A cap with post_cnt==1 stores that pc and goes to FROZEN. trig_en and trig_pc are ignored in POST.
  - FROZEN: no captures. opc, mem, count and wrapped hold. rd_data remains readable. Only clear or reset leaves FROZEN.
- frozen = (state == FROZEN), combinational from the state register.
- clear (synchronous):
  - wr_ptr, count, wrapped, post_cnt <= 0; opc <= 0; state <= RUN.
  - rd_data <= 0 on that cycle.
  - mem contents are not erased; they are masked by count = 0.
  - clear has priority over a cap in the same cycle, so that pc is discarded.
- reset: same effect as clear. All outputs read 0 in the cycle after reset. Reset mid-POST abandons the trigger.
- Compatibility: with DEPTH entries ignored, trig_en=0 and clear=0, opc is cycle-identical to the single-register OPC save.
- Wrap-around: the oldest entry is overwritten; count stays at DEPTH; index DEPTH-1 returns the oldest surviving entry.

Decomposition:
- Shared package opc_pkg:
  - state enum {RUN, POST, FROZEN} (2 bits).
  - Default PC_W = 14 constant.
  - Function computing the read address from wr_ptr and rd_idx.
- One sub-module, opc_hist_ram: DEPTH x PC_W register file with one write port and one registered read port.
- Control, trigger FSM and counters stay in opc_history.

Test Plan:
- Reset, then 3 caps via state_fetch with pc = 0x0100, 0x0101, 0x0102 → opc = 0x0102, count = 3; rd_idx 0/1/2 return 0x0102/0x0101/0x0100 one cycle later; rd_idx 3 returns 0.
- opcinh = 1 with state_fetch = 1 and pc = 0x3FFF → no change to opc/count. Then opcclk alone with pc = 0x0005 → opc = 0x0005.
- 10 caps of pc = 1..10 with DEPTH = 8 → count = 8, wrapped = 1, rd_idx 0 = 10, rd_idx 7 = 3.
- trig_en = 1, trig_pc = 0x0040, POST_TRIG = 2, pcs 0x3E..0x45 → frozen after the cap of 0x42; rd_idx 2 = 0x0040; further caps leave opc = 0x0042.
- clear asserted in the same cycle as a cap while FROZEN → count = 0, frozen = 0, opc = 0, rd_data = 0. The next cap records normally.
- Reset asserted while in POST (post_cnt = 1) → state RUN, all outputs 0; a subsequent match on trig_pc re-triggers.
